// File: rtl/systolic_mac_grid.sv
// Output-stationary DIM x DIM systolic MAC grid: A streams right, B streams down,
// and every cell accumulates a_in*b_in into its own C register (wrapping).
module systolic_mac_grid #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    localparam int CW     = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   WrEn,
    input  logic [CW-1:0]          Crow,
    input  logic [DIM*BITS_AB-1:0] A,
    input  logic [DIM*BITS_AB-1:0] B,
    input  logic [DIM*BITS_C-1:0]  Cin,
    output logic [DIM*BITS_C-1:0]  Cout
);
    localparam int PW = 2*BITS_AB + BITS_C;

    // Full signed product, then sign-extended or truncated to the accumulator width.
    function automatic logic [BITS_C-1:0] mac_term(input logic [BITS_AB-1:0] a,
                                                   input logic [BITS_AB-1:0] b);
        logic signed [PW-1:0] p;
        p = PW'(signed'(a)) * PW'(signed'(b));
        return p[BITS_C-1:0];
    endfunction

    logic [BITS_AB-1:0] a_r    [DIM][DIM];
    logic [BITS_AB-1:0] b_r    [DIM][DIM];
    logic [BITS_C-1:0]  c_r    [DIM][DIM];
    logic [BITS_AB-1:0] a_in_s [DIM][DIM];
    logic [BITS_AB-1:0] b_in_s [DIM][DIM];
    logic [BITS_C-1:0]  acc_s  [DIM][DIM];
    logic               row_ok_s;
    logic [DIM-1:0]     wr_hit_s;

    for (genvar r = 0; r < DIM; r++) begin : g_row
        for (genvar c = 0; c < DIM; c++) begin : g_col
            if (c == 0) begin : g_a_edge
                assign a_in_s[r][c] = A[r*BITS_AB +: BITS_AB];
            end else begin : g_a_int
                assign a_in_s[r][c] = a_r[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign b_in_s[r][c] = B[c*BITS_AB +: BITS_AB];
            end else begin : g_b_int
                assign b_in_s[r][c] = b_r[r-1][c];
            end
            assign acc_s[r][c] = c_r[r][c] + mac_term(a_in_s[r][c], b_in_s[r][c]);
        end
    end

    // Row decode for host writes; out-of-range rows never match.
    always_comb begin
        row_ok_s = (int'(Crow) < DIM);
        wr_hit_s = '0;
        for (int r = 0; r < DIM; r++) begin
            wr_hit_s[r] = WrEn && row_ok_s && (int'(Crow) == r);
        end
    end

    // Operand shift and accumulate; a host write to a row overrides its accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_r[r][c] <= '0;
                    b_r[r][c] <= '0;
                    c_r[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    if (en) begin
                        a_r[r][c] <= a_in_s[r][c];
                        b_r[r][c] <= b_in_s[r][c];
                    end
                    if (wr_hit_s[r]) begin
                        c_r[r][c] <= Cin[c*BITS_C +: BITS_C];
                    end else if (en) begin
                        c_r[r][c] <= acc_s[r][c];
                    end
                end
            end
        end
    end

    // Combinational readout of the selected row.
    always_comb begin
        Cout = '0;
        if (row_ok_s) begin
            for (int c = 0; c < DIM; c++) begin
                Cout[c*BITS_C +: BITS_C] = c_r[Crow][c];
            end
        end else begin
            Cout = '0;
        end
    end
endmodule

// File: tb/tb_systolic_mac_grid.sv
// Bench for systolic_mac_grid: directed and random steps checked against an
// operand-history model and a direct matrix-product golden result.
module tb_systolic_mac_grid;
    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int DIM     = 8;
    localparam int K       = 8;
    localparam int MAXT    = 2048;

    logic                   clk;
    logic                   rst_n;
    logic                   en;
    logic                   WrEn;
    logic [2:0]             Crow;
    logic [DIM*BITS_AB-1:0] A;
    logic [DIM*BITS_AB-1:0] B;
    logic [DIM*BITS_C-1:0]  Cin;
    logic [DIM*BITS_C-1:0]  Cout;

    systolic_mac_grid #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .Crow(Crow),
        .A(A), .B(B), .Cin(Cin), .Cout(Cout)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cur_a [DIM];
    int cur_b [DIM];
    int cur_cin [DIM];
    int ah [MAXT][DIM];
    int bh [MAXT][DIM];
    int tc;
    logic signed [15:0] mc [DIM][DIM];
    int am [DIM][K];
    int bm [K][DIM];

    function automatic int rs8();
        logic signed [7:0] t;
        t = 8'($urandom);
        return int'(t);
    endfunction

    task automatic model_reset();
        tc = 0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) mc[r][c] = 16'sd0;
    endtask

    // Cell (r,c) in enabled cycle t sees A[r] from cycle t-c and B[c] from cycle t-r.
    task automatic model_clock(input logic e, input logic w, input int row);
        int ai, bi;
        if (e) begin
            if (tc >= MAXT) begin
                $display("FAIL model_history overflow tc=%0d limit=%0d", tc, MAXT);
                $fatal(1);
            end
            for (int i = 0; i < DIM; i++) begin
                ah[tc][i] = cur_a[i];
                bh[tc][i] = cur_b[i];
            end
        end
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                if (w && row == r) begin
                    mc[r][c] = 16'(cur_cin[c]);
                end else if (e) begin
                    ai = (tc - c >= 0) ? ah[tc-c][r] : 0;
                    bi = (tc - r >= 0) ? bh[tc-r][c] : 0;
                    mc[r][c] = 16'(int'(mc[r][c]) + ai * bi);
                end
            end
        end
        if (e) tc++;
    endtask

    task automatic drive();
        for (int i = 0; i < DIM; i++) begin
            A[i*BITS_AB +: BITS_AB] = 8'(cur_a[i]);
            B[i*BITS_AB +: BITS_AB] = 8'(cur_b[i]);
            Cin[i*BITS_C +: BITS_C] = 16'(cur_cin[i]);
        end
    endtask

    task automatic zero_inputs();
        for (int i = 0; i < DIM; i++) begin
            cur_a[i] = 0;
            cur_b[i] = 0;
            cur_cin[i] = 0;
        end
    endtask

    task automatic random_inputs();
        for (int i = 0; i < DIM; i++) begin
            cur_a[i] = rs8();
            cur_b[i] = rs8();
            cur_cin[i] = int'($urandom_range(0, 65535));
        end
    endtask

    // Starts and ends on a negedge; the model advances right after the posedge.
    task automatic step(input logic e, input logic w, input int row);
        en = e;
        WrEn = w;
        Crow = 3'(row);
        drive();
        @(posedge clk);
        model_clock(e, w, row);
        @(negedge clk);
    endtask

    task automatic check_rows(input string tag);
        logic [DIM*BITS_C-1:0] exp;
        for (int r = 0; r < DIM; r++) begin
            Crow = 3'(r);
            #1;
            for (int c = 0; c < DIM; c++) exp[c*BITS_C +: BITS_C] = mc[r][c];
            tests++;
            assert (Cout === exp) else begin
                fails++;
                $error("FAIL %s row %0d: got %h expected %h", tag, r, Cout, exp);
            end
        end
    endtask

    task automatic check_cell(input string tag, input int r, input int c, input int v);
        logic [15:0] got;
        logic [15:0] exp;
        Crow = 3'(r);
        #1;
        got = Cout[c*BITS_C +: BITS_C];
        exp = 16'(v);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s C(%0d,%0d): got %0d expected %0d", tag, r, c, $signed(got), $signed(exp));
        end
    endtask

    task automatic check_golden(input string tag);
        logic [DIM*BITS_C-1:0] exp;
        int s;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                s = 0;
                for (int k = 0; k < K; k++) s += am[r][k] * bm[k][c];
                exp[c*BITS_C +: BITS_C] = 16'(s);
            end
            Crow = 3'(r);
            #1;
            tests++;
            assert (Cout === exp) else begin
                fails++;
                $error("FAIL %s row %0d: got %h expected %h", tag, r, Cout, exp);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_matrices();
        for (int i = 0; i < DIM; i++)
            for (int k = 0; k < K; k++) begin
                am[i][k] = rs8();
                bm[k][i] = rs8();
            end
    endtask

    // Skewed feed: row r carries A[r][t-r], column c carries B[t-c][c].
    task automatic feed(input int hold_at);
        for (int t = 0; t < K + 2*(DIM-1); t++) begin
            if (t == hold_at) begin
                check_rows("pre_hold");
                for (int h = 0; h < 5; h++) begin
                    random_inputs();
                    step(1'b0, 1'b0, int'($urandom_range(0, 7)));
                end
                check_rows("hold");
            end
            for (int i = 0; i < DIM; i++) begin
                cur_a[i] = (t - i >= 0 && t - i < K) ? am[i][t-i] : 0;
                cur_b[i] = (t - i >= 0 && t - i < K) ? bm[t-i][i] : 0;
                cur_cin[i] = 0;
            end
            step(1'b1, 1'b0, 0);
        end
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; WrEn = 1'b0; Crow = 3'd0;
        A = '0; B = '0; Cin = '0;
        model_reset();
        #5 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            random_inputs();
            en = 1'($urandom);
            WrEn = 1'b1;
            Crow = 3'($urandom_range(0, 7));
            drive();
            @(negedge clk);
        end
        check_rows("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            random_inputs();
            step(1'b0, 1'b0, 0);
        end
        check_rows("post_reset_hold");

        zero_inputs();
        cur_a[0] = 3;
        cur_b[0] = -4;
        step(1'b1, 1'b0, 0);
        zero_inputs();
        check_rows("single_mac");
        check_cell("single_c00", 0, 0, -12);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        check_rows("single_mac_keep");
        check_cell("single_c00_keep", 0, 0, -12);

        do_reset();
        random_matrices();
        feed(-1);
        check_golden("full_product");

        do_reset();
        random_matrices();
        feed(10);
        check_golden("hold_resume");

        random_inputs();
        for (int i = 0; i < DIM; i++) begin
            if (cur_a[i] == 0) cur_a[i] = 1;
            if (cur_b[i] == 0) cur_b[i] = -1;
            cur_cin[i] = 100;
        end
        step(1'b1, 1'b1, 2);
        check_rows("write_prio");
        check_cell("write_row2", 2, 5, 100);

        for (int i = 0; i < 40; i++) begin
            random_inputs();
            step(1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)));
            if (i % 8 == 7) check_rows("random");
        end

        do_reset();
        zero_inputs();
        for (int i = 0; i < DIM; i++) cur_cin[i] = 32767;
        step(1'b0, 1'b1, 0);
        zero_inputs();
        cur_a[0] = 1;
        cur_b[0] = 1;
        step(1'b1, 1'b0, 0);
        zero_inputs();
        check_cell("wrap", 0, 0, -32768);
        check_rows("wrap_rows");

        for (int i = 0; i < 5; i++) begin
            random_inputs();
            step(1'b1, 1'b0, 0);
        end
        check_rows("pre_async_reset");
        rst_n = 1'b0;
        model_reset();
        check_rows("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        zero_inputs();
        step(1'b1, 1'b0, 0);
        check_rows("after_async_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
